seq_instruction_decoder: RTL and testbench
==========================================

Name: seq_instruction_decoder

Overview:
- Parametrised multi-cycle successor to the single-cycle instruction decoder. It sits between the instruction register/program ROM and the datapath (ALU, ACC, R0, RAM, PC, stack), driving the same control signals.
- Adds a sequencer that executes MOV A,#addr and MOV #addr,A correctly over MEM_LAT+1 cycles, stalling the PC via BUSY.
- Tracks stack depth and blocks stack overflow and underflow, reporting them through a sticky fault flag.

Parameters:
- INSTR_WIDTH, 5, opcode width; opcodes at or above 0x20 decode as NOP.
- OP_WIDTH, 4, ALU op field width; table values are zero-extended into OP.
- MEM_LAT, 1, RAM access latency in cycles (≥1); a memory opcode takes MEM_LAT+1 cycles.
- STACK_DEPTH, 8, hardware stack entries.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- INSTRUCTION  in  INSTR_WIDTH  opcode; must be held stable while BUSY=1.
- INSTR_VALID  in  1  opcode present this cycle.
- RESET_INSTR, MEM_SEL, CE_R0, CE_ACC, REG_WR, CE_RAM, CE_PC, CE_STACK, nRW_STACK, STACK_SEL, PC_SEL  out  1 each  datapath controls.
- MUX_SEL  out  2  datapath mux select.
- OP  out  OP_WIDTH  ALU operation.
- BUSY  out  1  multi-cycle op in progress; PC/IR must hold.
- SP  out  clog2(STACK_DEPTH+1)  current stack occupancy.
- STACK_FAULT  out  1  sticky overflow/underflow flag.

Behaviour:
- Control word order, MSB→LSB: {PC_SEL, STACK_SEL, CE_STACK, nRW_STACK, CE_PC, CE_RAM, MEM_SEL, OP[3:0], RESET_INSTR, MUX_SEL, CE_ACC, REG_WR}. CE_R0 is always 0.
- Single-cycle words (hex):
  - 00 NOT=0012, 01 XOR=0032, 02 OR=0052, 03 AND=0072
  - 04 SUB=0092, 05 ADD=00B2, 06 RR=00D2, 07 RL=00F2
  - 08 DEC=0112, 09 INC=0132, 0A LD=0172, 0B ST=0151
  - 0C NOP=0150, 0D LDI=0156, 0E JMP=0950, 0F RST=0140
  - 12 PUSH=3150, 13 POP=215A, 14 CALL=7950, 15 RET=A950
  - 16–1E NOP=0150, 1F RST=0140
- Memory opcodes:
  - 10 MOV A,#addr: setup word 0040, commit word 0372.
  - 11 MOV #addr,A: setup word 0040, commit word 0550.
- Outputs are combinational from state, latched IR and INSTRUCTION. State, IR, SP and STACK_FAULT are registered.
- FSM states are IDLE, WAIT and COMMIT.
- IDLE:
  - INSTR_VALID=0 → all controls 0, BUSY=0.
  - Single-cycle opcode → its word in the same cycle, BUSY=0, stay in IDLE.
  - Opcode 10/11 → setup word, BUSY=1, IR←INSTRUCTION. Go to WAIT if MEM_LAT>1, else to COMMIT.
- WAIT: setup word, BUSY=1, counts MEM_LAT-1 cycles (counter reloads on each entry), then goes to COMMIT.
- COMMIT: commit word for IR, BUSY=0. The next cycle is IDLE and accepts a new opcode; back-to-back memory opcodes are legal.
- INSTRUCTION is ignored while in WAIT or COMMIT.
- Stack accounting, evaluated on the cycle the word is issued:
  - PUSH and CALL increment SP. POP and RET decrement SP.
  - PUSH or CALL with SP==STACK_DEPTH → overflow. POP or RET with SP==0 → underflow.
  - On a fault: the output word is replaced by NOP 0150, SP is unchanged, STACK_FAULT←1. The flag clears only on RST.
  - Stack opcodes never coincide with the multi-cycle path.
- RST=1:
  - Next edge: state←IDLE, SP←0, STACK_FAULT←0, IR←0, wait counter←0.
  - While RST is high, all control outputs and BUSY are forced to 0 combinationally.
  - Reset mid-sequence abandons the memory op, and no commit word is issued.
- The RST opcode (0F/1F) only drives its control word; it does not reset this block's SP or fault flag.

Test Plan:
- RST for 2 cycles, then opcodes 00..0F,12..15 each with INSTR_VALID=1 → each word matches the table (e.g. 05→00B2, 0E→0950), BUSY=0 throughout; SP goes 0→1 (PUSH) →0 (POP) →1 (CALL) →0 (RET).
- MEM_LAT=1, opcode 10 then 0A → cycle0 word 0040 BUSY=1; cycle1 word 0372 BUSY=0; cycle2 word 0172.
- MEM_LAT=3, opcode 11 → 0040/BUSY=1 for 3 cycles, then 0550/BUSY=0, then IDLE. Changing INSTRUCTION to 00 mid-sequence has no effect.
- STACK_DEPTH=2: PUSH, PUSH, PUSH → third cycle output 0150, SP stays 2, STACK_FAULT=1 and remains 1 after a following POP (SP→1).
- From reset, POP → output 0150, SP=0, STACK_FAULT=1; RST → STACK_FAULT=0.
- MEM_LAT=3, opcode 10, RST asserted in WAIT → outputs 0 during RST, no 0372 issued; after release, opcode 09 → 0132 immediately.

Source files
------------

// File: rtl/seq_instruction_decoder_if.sv
// -----------------------------------------------------------------------------
// seq_instruction_decoder_if
//
// Bundles the opcode handshake and the datapath control outputs of the
// sequential instruction decoder.
//
//   master modport (instruction register / program ROM side):
//     drives  INSTRUCTION, INSTR_VALID
//     samples every control output, BUSY, SP and STACK_FAULT
//   slave modport (decoder side):
//     samples INSTRUCTION, INSTR_VALID
//     drives  RESET_INSTR, MEM_SEL, CE_R0, CE_ACC, REG_WR, CE_RAM, CE_PC,
//             CE_STACK, nRW_STACK, STACK_SEL, PC_SEL, MUX_SEL, OP,
//             BUSY, SP, STACK_FAULT
//
// SP_WIDTH must equal $clog2(STACK_DEPTH+1) of the attached decoder.
// -----------------------------------------------------------------------------
interface seq_instruction_decoder_if #(
    parameter int INSTR_WIDTH = 5,
    parameter int OP_WIDTH    = 4,
    parameter int SP_WIDTH    = 4
);
    logic [INSTR_WIDTH-1:0] INSTRUCTION;
    logic                   INSTR_VALID;

    logic                   RESET_INSTR;
    logic                   MEM_SEL;
    logic                   CE_R0;
    logic                   CE_ACC;
    logic                   REG_WR;
    logic                   CE_RAM;
    logic                   CE_PC;
    logic                   CE_STACK;
    logic                   nRW_STACK;
    logic                   STACK_SEL;
    logic                   PC_SEL;
    logic [1:0]             MUX_SEL;
    logic [OP_WIDTH-1:0]    OP;

    logic                   BUSY;
    logic [SP_WIDTH-1:0]    SP;
    logic                   STACK_FAULT;

    modport master (
        output INSTRUCTION, INSTR_VALID,
        input  RESET_INSTR, MEM_SEL, CE_R0, CE_ACC, REG_WR, CE_RAM, CE_PC,
               CE_STACK, nRW_STACK, STACK_SEL, PC_SEL, MUX_SEL, OP,
               BUSY, SP, STACK_FAULT
    );

    modport slave (
        input  INSTRUCTION, INSTR_VALID,
        output RESET_INSTR, MEM_SEL, CE_R0, CE_ACC, REG_WR, CE_RAM, CE_PC,
               CE_STACK, nRW_STACK, STACK_SEL, PC_SEL, MUX_SEL, OP,
               BUSY, SP, STACK_FAULT
    );
endinterface

// File: rtl/seq_instruction_decoder.sv
// -----------------------------------------------------------------------------
// seq_instruction_decoder
//
// Multi-cycle instruction decoder. Single-cycle opcodes are decoded
// combinationally into a 16-bit control word. The two memory moves
// (0x10 MOV A,#addr and 0x11 MOV #addr,A) are sequenced over MEM_LAT+1
// cycles: a setup word with BUSY=1 for MEM_LAT cycles, then the commit word.
// A stack-depth counter guards PUSH/CALL against overflow and POP/RET
// against underflow; a blocked stack op issues NOP and sets a sticky fault.
//
// Ports:
//   CLK  clock
//   RST  synchronous active-high reset; also blanks all outputs while high
//   bus  seq_instruction_decoder_if.slave
//        INSTRUCTION/INSTR_VALID in; control word, BUSY, SP, STACK_FAULT out
//
// Control word layout, MSB..LSB:
//   {PC_SEL, STACK_SEL, CE_STACK, nRW_STACK, CE_PC, CE_RAM, MEM_SEL,
//    OP[3:0], RESET_INSTR, MUX_SEL[1:0], CE_ACC, REG_WR}
// -----------------------------------------------------------------------------
module seq_instruction_decoder #(
    parameter int INSTR_WIDTH = 5,
    parameter int OP_WIDTH    = 4,
    parameter int MEM_LAT     = 1,
    parameter int STACK_DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    seq_instruction_decoder_if.slave bus
);

    localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    // WAIT lasts MEM_LAT-1 cycles, so the counter loads MEM_LAT-2 and
    // leaves WAIT when it reaches zero.
    localparam int CNT_WIDTH = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_RELOAD =
        CNT_WIDTH'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [SP_WIDTH-1:0]  SP_FULL    = SP_WIDTH'(STACK_DEPTH);

    localparam logic [15:0] WORD_ZERO      = 16'h0000;
    localparam logic [15:0] WORD_SETUP     = 16'h0040;
    localparam logic [15:0] WORD_NOP       = 16'h0150;
    localparam logic [15:0] WORD_MOV_LOAD  = 16'h0372;
    localparam logic [15:0] WORD_MOV_STORE = 16'h0550;

    localparam logic [INSTR_WIDTH-1:0] IR_MOV_STORE = INSTR_WIDTH'(5'h11);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Control word for every single-cycle opcode. 0x10/0x11 never reach
    // this table because the memory path intercepts them first.
    function automatic logic [15:0] single_word(input logic [4:0] opc);
        logic [15:0] w;
        case (opc)
            5'h00:   w = 16'h0012;  // NOT
            5'h01:   w = 16'h0032;  // XOR
            5'h02:   w = 16'h0052;  // OR
            5'h03:   w = 16'h0072;  // AND
            5'h04:   w = 16'h0092;  // SUB
            5'h05:   w = 16'h00B2;  // ADD
            5'h06:   w = 16'h00D2;  // RR
            5'h07:   w = 16'h00F2;  // RL
            5'h08:   w = 16'h0112;  // DEC
            5'h09:   w = 16'h0132;  // INC
            5'h0A:   w = 16'h0172;  // LD
            5'h0B:   w = 16'h0151;  // ST
            5'h0C:   w = 16'h0150;  // NOP
            5'h0D:   w = 16'h0156;  // LDI
            5'h0E:   w = 16'h0950;  // JMP
            5'h0F:   w = 16'h0140;  // RST
            5'h12:   w = 16'h3150;  // PUSH
            5'h13:   w = 16'h215A;  // POP
            5'h14:   w = 16'h7950;  // CALL
            5'h15:   w = 16'h A950;  // RET
            5'h1F:   w = 16'h0140;  // RST
            default: w = WORD_NOP;  // 0x16..0x1E and anything unassigned
        endcase
        return w;
    endfunction

    // Commit word of a memory move, selected by the latched opcode.
    function automatic logic [15:0] commit_word(input logic [INSTR_WIDTH-1:0] ir);
        logic [15:0] w;
        if (ir == IR_MOV_STORE) begin
            w = WORD_MOV_STORE;
        end else begin
            w = WORD_MOV_LOAD;
        end
        return w;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [INSTR_WIDTH-1:0] ir_q,    ir_d;
    logic [SP_WIDTH-1:0]    sp_q,    sp_d;
    logic                   fault_q, fault_d;

    logic [4:0]  opc_s;
    logic        opc_hi_s;
    logic        issue_s;
    logic        mem_op_s;
    logic        push_s;
    logic        pop_s;
    logic        overflow_s;
    logic        underflow_s;
    logic [15:0] word_s;
    logic        busy_s;

    assign opc_s = bus.INSTRUCTION[4:0];

    // Opcodes at or above 0x20 decode as NOP; only wider opcodes can reach them.
    generate
        if (INSTR_WIDTH > 5) begin : g_opc_hi
            assign opc_hi_s = |bus.INSTRUCTION[INSTR_WIDTH-1:5];
        end else begin : g_opc_lo
            assign opc_hi_s = 1'b0;
        end
    endgenerate

    // A new opcode is only looked at in IDLE; WAIT/COMMIT ignore INSTRUCTION.
    assign issue_s     = (state_q == ST_IDLE) && bus.INSTR_VALID && !opc_hi_s;
    assign mem_op_s    = issue_s && ((opc_s == 5'h10) || (opc_s == 5'h11));
    assign push_s      = issue_s && ((opc_s == 5'h12) || (opc_s == 5'h14));
    assign pop_s       = issue_s && ((opc_s == 5'h13) || (opc_s == 5'h15));
    assign overflow_s  = push_s && (sp_q == SP_FULL);
    assign underflow_s = pop_s  && (sp_q == {SP_WIDTH{1'b0}});

    // State, wait counter, latched opcode, stack pointer and fault flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_WIDTH{1'b0}};
            ir_q    <= {INSTR_WIDTH{1'b0}};
            sp_q    <= {SP_WIDTH{1'b0}};
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic for the sequencer and the stack accounting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        sp_d    = sp_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s) begin
                    ir_d = bus.INSTRUCTION;
                    if (MEM_LAT > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else if (overflow_s || underflow_s) begin
                    // Blocked stack op: SP holds, the flag sticks until RST.
                    fault_d = 1'b1;
                end else if (push_s) begin
                    sp_d = sp_q + {{(SP_WIDTH-1){1'b0}}, 1'b1};
                end else if (pop_s) begin
                    sp_d = sp_q - {{(SP_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_WIDTH{1'b0}}) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: control word and BUSY from state, IR and INSTRUCTION.
    always_comb begin
        word_s = WORD_ZERO;
        busy_s = 1'b0;
        if (RST) begin
            // Outputs are blanked for the whole reset, even mid-sequence.
            word_s = WORD_ZERO;
            busy_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.INSTR_VALID) begin
                        word_s = WORD_ZERO;
                    end else if (opc_hi_s) begin
                        word_s = WORD_NOP;
                    end else if (mem_op_s) begin
                        word_s = WORD_SETUP;
                        busy_s = 1'b1;
                    end else if (overflow_s || underflow_s) begin
                        word_s = WORD_NOP;
                    end else begin
                        word_s = single_word(opc_s);
                    end
                end
                ST_WAIT: begin
                    word_s = WORD_SETUP;
                    busy_s = 1'b1;
                end
                ST_COMMIT: begin
                    word_s = commit_word(ir_q);
                end
                default: begin
                    word_s = WORD_ZERO;
                end
            endcase
        end
    end

    assign bus.PC_SEL      = word_s[15];
    assign bus.STACK_SEL   = word_s[14];
    assign bus.CE_STACK    = word_s[13];
    assign bus.nRW_STACK   = word_s[12];
    assign bus.CE_PC       = word_s[11];
    assign bus.CE_RAM      = word_s[10];
    assign bus.MEM_SEL     = word_s[9];
    assign bus.OP          = OP_WIDTH'(word_s[8:5]);
    assign bus.RESET_INSTR = word_s[4];
    assign bus.MUX_SEL     = word_s[3:2];
    assign bus.CE_ACC      = word_s[1];
    assign bus.REG_WR      = word_s[0];
    assign bus.CE_R0       = 1'b0;
    assign bus.BUSY        = busy_s;
    assign bus.SP          = sp_q;
    assign bus.STACK_FAULT = fault_q;

endmodule

// File: tb/tb_seq_instruction_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_instruction_decoder
//
// Three decoder instances share one clock:
//   0: MEM_LAT=1, STACK_DEPTH=8   1: MEM_LAT=3, STACK_DEPTH=8
//   2: MEM_LAT=1, STACK_DEPTH=2
// A behavioural model (remaining-cycle count of the memory move, stack
// occupancy as an integer, sticky fault bit) predicts every output of every
// instance each cycle; directed literal checks pin the model to hand values.
// -----------------------------------------------------------------------------
module tb_seq_instruction_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] t_op  [3];
    logic       t_v   [3];
    logic       t_rst [3];

    seq_instruction_decoder_if #(.INSTR_WIDTH(5), .OP_WIDTH(4), .SP_WIDTH(4)) if_a ();
    seq_instruction_decoder_if #(.INSTR_WIDTH(5), .OP_WIDTH(4), .SP_WIDTH(4)) if_b ();
    seq_instruction_decoder_if #(.INSTR_WIDTH(5), .OP_WIDTH(4), .SP_WIDTH(2)) if_c ();

    seq_instruction_decoder #(.INSTR_WIDTH(5), .OP_WIDTH(4), .MEM_LAT(1), .STACK_DEPTH(8))
        dut_a (.CLK(clk), .RST(t_rst[0]), .bus(if_a.slave));
    seq_instruction_decoder #(.INSTR_WIDTH(5), .OP_WIDTH(4), .MEM_LAT(3), .STACK_DEPTH(8))
        dut_b (.CLK(clk), .RST(t_rst[1]), .bus(if_b.slave));
    seq_instruction_decoder #(.INSTR_WIDTH(5), .OP_WIDTH(4), .MEM_LAT(1), .STACK_DEPTH(2))
        dut_c (.CLK(clk), .RST(t_rst[2]), .bus(if_c.slave));

    assign if_a.INSTRUCTION = t_op[0];
    assign if_a.INSTR_VALID = t_v[0];
    assign if_b.INSTRUCTION = t_op[1];
    assign if_b.INSTR_VALID = t_v[1];
    assign if_c.INSTRUCTION = t_op[2];
    assign if_c.INSTR_VALID = t_v[2];

    // Observed outputs as {CE_R0, 16-bit control word}.
    logic [16:0] dw     [3];
    logic        db     [3];
    logic [3:0]  dsp    [3];
    logic        dfault [3];

    assign dw[0] = {if_a.CE_R0, if_a.PC_SEL, if_a.STACK_SEL, if_a.CE_STACK, if_a.nRW_STACK,
                    if_a.CE_PC, if_a.CE_RAM, if_a.MEM_SEL, if_a.OP, if_a.RESET_INSTR,
                    if_a.MUX_SEL, if_a.CE_ACC, if_a.REG_WR};
    assign dw[1] = {if_b.CE_R0, if_b.PC_SEL, if_b.STACK_SEL, if_b.CE_STACK, if_b.nRW_STACK,
                    if_b.CE_PC, if_b.CE_RAM, if_b.MEM_SEL, if_b.OP, if_b.RESET_INSTR,
                    if_b.MUX_SEL, if_b.CE_ACC, if_b.REG_WR};
    assign dw[2] = {if_c.CE_R0, if_c.PC_SEL, if_c.STACK_SEL, if_c.CE_STACK, if_c.nRW_STACK,
                    if_c.CE_PC, if_c.CE_RAM, if_c.MEM_SEL, if_c.OP, if_c.RESET_INSTR,
                    if_c.MUX_SEL, if_c.CE_ACC, if_c.REG_WR};
    assign db[0] = if_a.BUSY;
    assign db[1] = if_b.BUSY;
    assign db[2] = if_c.BUSY;
    assign dsp[0] = if_a.SP;
    assign dsp[1] = if_b.SP;
    assign dsp[2] = {2'b00, if_c.SP};
    assign dfault[0] = if_a.STACK_FAULT;
    assign dfault[1] = if_b.STACK_FAULT;
    assign dfault[2] = if_c.STACK_FAULT;

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Reference control words from the opcode table (CE_R0 bit is 0).
    function automatic logic [16:0] ref_word(input logic [4:0] op);
        case (op)
            5'h00: return 17'h00012;  5'h01: return 17'h00032;
            5'h02: return 17'h00052;  5'h03: return 17'h00072;
            5'h04: return 17'h00092;  5'h05: return 17'h000B2;
            5'h06: return 17'h000D2;  5'h07: return 17'h000F2;
            5'h08: return 17'h00112;  5'h09: return 17'h00132;
            5'h0A: return 17'h00172;  5'h0B: return 17'h00151;
            5'h0C: return 17'h00150;  5'h0D: return 17'h00156;
            5'h0E: return 17'h00950;  5'h0F: return 17'h00140;
            5'h12: return 17'h03150;  5'h13: return 17'h0215A;
            5'h14: return 17'h07950;  5'h15: return 17'h0A950;
            5'h1F: return 17'h00140;
            default: return 17'h00150;
        endcase
    endfunction

    // Model state: cycles left in a memory move (0 = free), latched opcode,
    // stack occupancy and sticky fault.
    int          lat   [3] = '{1, 3, 1};
    int          depth [3] = '{8, 8, 2};
    int          m_rem [3] = '{0, 0, 0};
    logic [4:0]  m_ir  [3] = '{5'h00, 5'h00, 5'h00};
    int          m_sp  [3] = '{0, 0, 0};
    logic        m_flt [3] = '{1'b0, 1'b0, 1'b0};
    logic [16:0] m_ew;
    logic        m_eb;

    // Compare every instance against the model, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                m_ew = 17'h00000;
                m_eb = 1'b0;
                if (t_rst[k]) begin
                    m_ew = 17'h00000;
                end else if (m_rem[k] > 0) begin
                    if (m_rem[k] == 1) begin
                        m_ew = (m_ir[k] == 5'h11) ? 17'h00550 : 17'h00372;
                    end else begin
                        m_ew = 17'h00040;
                        m_eb = 1'b1;
                    end
                end else if (!t_v[k]) begin
                    m_ew = 17'h00000;
                end else if (t_op[k] == 5'h10 || t_op[k] == 5'h11) begin
                    m_ew = 17'h00040;
                    m_eb = 1'b1;
                end else if ((t_op[k] == 5'h12 || t_op[k] == 5'h14) && m_sp[k] == depth[k]) begin
                    m_ew = 17'h00150;
                end else if ((t_op[k] == 5'h13 || t_op[k] == 5'h15) && m_sp[k] == 0) begin
                    m_ew = 17'h00150;
                end else begin
                    m_ew = ref_word(t_op[k]);
                end

                check("word",  k, {15'd0, dw[k]}, {15'd0, m_ew});
                check("busy",  k, {31'd0, db[k]}, {31'd0, m_eb});
                check("sp",    k, {28'd0, dsp[k]}, m_sp[k]);
                check("fault", k, {31'd0, dfault[k]}, {31'd0, m_flt[k]});

                if (t_rst[k]) begin
                    m_rem[k] = 0;
                    m_ir[k]  = 5'h00;
                    m_sp[k]  = 0;
                    m_flt[k] = 1'b0;
                end else if (m_rem[k] > 0) begin
                    m_rem[k] = m_rem[k] - 1;
                end else if (t_v[k]) begin
                    if (t_op[k] == 5'h10 || t_op[k] == 5'h11) begin
                        m_rem[k] = lat[k];
                        m_ir[k]  = t_op[k];
                    end else if (t_op[k] == 5'h12 || t_op[k] == 5'h14) begin
                        if (m_sp[k] == depth[k]) m_flt[k] = 1'b1;
                        else m_sp[k] = m_sp[k] + 1;
                    end else if (t_op[k] == 5'h13 || t_op[k] == 5'h15) begin
                        if (m_sp[k] == 0) m_flt[k] = 1'b1;
                        else m_sp[k] = m_sp[k] - 1;
                    end
                end
            end
        end
    end

    task automatic drive(input int k, input logic r, input logic v, input logic [4:0] op);
        @(posedge clk);
        #1;
        t_rst[k] = r;
        t_v[k]   = v;
        t_op[k]  = op;
    endtask

    task automatic lit_word(input string name, input int k, input logic [16:0] exp_w,
                            input logic exp_b);
        @(negedge clk);
        check(name, k, {15'd0, dw[k]}, {15'd0, exp_w});
        check({name, "_busy"}, k, {31'd0, db[k]}, {31'd0, exp_b});
    endtask

    task automatic lit_stack(input string name, input int k, input int exp_sp,
                             input logic exp_f);
        @(negedge clk);
        check({name, "_sp"}, k, {28'd0, dsp[k]}, exp_sp);
        check({name, "_fault"}, k, {31'd0, dfault[k]}, {31'd0, exp_f});
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            t_rst[k] = 1'b1;
            t_v[k]   = 1'b0;
            t_op[k]  = 5'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        // Third reset cycle: outputs blanked, SP and fault cleared.
        lit_word("reset_word", 0, 17'h00000, 1'b0);
        check("reset_sp", 0, {28'd0, dsp[0]}, 32'd0);
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 5'h00);

        // All single-cycle opcodes on instance 0.
        for (int i = 0; i < 32; i++) begin
            if (i != 16 && i != 17) begin
                drive(0, 1'b0, 1'b1, 5'(i));
                @(negedge clk);
                if (i == 5)  check("lit_add", 0, {15'd0, dw[0]}, 32'h000B2);
                if (i == 14) check("lit_jmp", 0, {15'd0, dw[0]}, 32'h00950);
                if (i == 19) check("lit_sp_after_push", 0, {28'd0, dsp[0]}, 32'd1);
                if (i == 21) check("lit_sp_after_call", 0, {28'd0, dsp[0]}, 32'd1);
            end
        end
        drive(0, 1'b0, 1'b0, 5'h00);
        lit_stack("after_ret", 0, 0, 1'b0);

        // MEM_LAT=1: MOV A,#addr then LD.
        drive(0, 1'b0, 1'b1, 5'h10);
        lit_word("mov_ld_setup", 0, 17'h00040, 1'b1);
        drive(0, 1'b0, 1'b1, 5'h10);
        lit_word("mov_ld_commit", 0, 17'h00372, 1'b0);
        drive(0, 1'b0, 1'b1, 5'h0A);
        lit_word("ld_after_mov", 0, 17'h00172, 1'b0);
        // Back-to-back memory moves.
        drive(0, 1'b0, 1'b1, 5'h11);
        drive(0, 1'b0, 1'b1, 5'h11);
        lit_word("mov_st_commit_a", 0, 17'h00550, 1'b0);
        drive(0, 1'b0, 1'b1, 5'h10);
        lit_word("b2b_setup", 0, 17'h00040, 1'b1);
        drive(0, 1'b0, 1'b0, 5'h00);
        lit_word("b2b_commit", 0, 17'h00372, 1'b0);

        // MEM_LAT=3: MOV #addr,A with INSTRUCTION changed mid-sequence.
        drive(1, 1'b0, 1'b1, 5'h11);
        lit_word("lat3_setup0", 1, 17'h00040, 1'b1);
        drive(1, 1'b0, 1'b1, 5'h00);
        lit_word("lat3_setup1", 1, 17'h00040, 1'b1);
        drive(1, 1'b0, 1'b1, 5'h00);
        lit_word("lat3_setup2", 1, 17'h00040, 1'b1);
        drive(1, 1'b0, 1'b1, 5'h00);
        lit_word("lat3_commit", 1, 17'h00550, 1'b0);
        drive(1, 1'b0, 1'b0, 5'h00);
        lit_word("lat3_idle", 1, 17'h00000, 1'b0);

        // STACK_DEPTH=2: overflow on the third PUSH, sticky across a POP.
        drive(2, 1'b0, 1'b1, 5'h12);
        drive(2, 1'b0, 1'b1, 5'h12);
        drive(2, 1'b0, 1'b1, 5'h12);
        lit_word("ovf_word", 2, 17'h00150, 1'b0);
        drive(2, 1'b0, 1'b1, 5'h13);
        lit_stack("ovf_before_pop", 2, 2, 1'b1);
        drive(2, 1'b0, 1'b0, 5'h00);
        lit_stack("ovf_after_pop", 2, 1, 1'b1);
        drive(2, 1'b0, 1'b1, 5'h14);
        drive(2, 1'b0, 1'b1, 5'h14);
        lit_word("ovf_call", 2, 17'h00150, 1'b0);
        drive(2, 1'b0, 1'b0, 5'h00);

        // Underflow from empty stack, cleared only by RST; RST opcode keeps it.
        drive(0, 1'b0, 1'b1, 5'h13);
        lit_word("udf_word", 0, 17'h00150, 1'b0);
        drive(0, 1'b0, 1'b1, 5'h0F);
        lit_stack("udf_after", 0, 0, 1'b1);
        drive(0, 1'b0, 1'b0, 5'h00);
        lit_stack("udf_rst_opcode", 0, 0, 1'b1);
        drive(0, 1'b1, 1'b0, 5'h00);
        drive(0, 1'b0, 1'b0, 5'h00);
        lit_stack("udf_cleared", 0, 0, 1'b0);

        // MEM_LAT=3: reset during WAIT abandons the move.
        drive(1, 1'b0, 1'b1, 5'h10);
        drive(1, 1'b0, 1'b1, 5'h10);
        lit_word("abort_wait", 1, 17'h00040, 1'b1);
        drive(1, 1'b1, 1'b1, 5'h10);
        lit_word("abort_rst", 1, 17'h00000, 1'b0);
        drive(1, 1'b0, 1'b1, 5'h09);
        lit_word("abort_inc", 1, 17'h00132, 1'b0);
        drive(1, 1'b0, 1'b0, 5'h00);
        lit_word("abort_no_commit", 1, 17'h00000, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
